// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: operand forwarding plus load-use, branch and multi-cycle
// execute hazard control for the 5-stage core. Drives the forwarding muxes and
// the F/D/E/M pipeline-register stall/flush controls.
module hazard_unit_mc #(
    parameter int REG_AW         = 5,
    parameter int LOAD_STALL_CYC = 1,   // 1..7
    parameter int MC_TIMEOUT     = 64   // 2..255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic              McDoneE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              McBusy,
    output logic              McTimeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LD_STALL,
        S_MC_BUSY
    } state_t;

    // Counter reload/terminal values, sized to the counter widths.
    localparam logic [2:0] LD_INIT = 3'(LOAD_STALL_CYC - 1);
    localparam logic [7:0] MC_LAST = 8'(MC_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] ld_cnt_q, ld_cnt_d;
    logic [7:0] mc_cnt_q, mc_cnt_d;
    logic       mc_timeout_q, mc_timeout_d;
    logic       ld_haz;

    // M stage wins over W because it holds the younger result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rd_m,
                                           input logic              we_m,
                                           input logic [REG_AW-1:0] rd_w,
                                           input logic              we_w);
        if (rs != '0 && rs == rd_m && we_m)
            return 2'b10;
        else if (rs != '0 && rs == rd_w && we_w)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Forwarding mux selects, forced to the register file while in reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        end
    end

    assign ld_haz = ResultSrcE0 & RegWriteE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // Next-state, counters and stall/flush outputs for the hazard FSM.
    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        mc_cnt_d     = mc_cnt_q;
        mc_timeout_d = mc_timeout_q;
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushM       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A taken branch makes D wrong-path, so it outranks everything.
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (McStartE) begin
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    FlushM   = 1'b1;
                    mc_cnt_d = 8'd0;
                    state_d  = S_MC_BUSY;
                end else if (ld_haz) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        ld_cnt_d = LD_INIT;
                        state_d  = S_LD_STALL;
                    end
                end
            end
            S_LD_STALL: begin
                // E already holds a bubble, so nothing new can be detected here.
                StallF   = 1'b1;
                StallD   = 1'b1;
                FlushE   = 1'b1;
                ld_cnt_d = ld_cnt_q - 3'd1;
                if (ld_cnt_q <= 3'd1)
                    state_d = S_IDLE;
            end
            S_MC_BUSY: begin
                // Done releases the pipe in the same cycle so the result moves to M.
                if (McDoneE) begin
                    state_d = S_IDLE;
                end else begin
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    FlushM   = 1'b1;
                    mc_cnt_d = mc_cnt_q + 8'd1;
                    if (mc_cnt_q == MC_LAST) begin
                        mc_timeout_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushM = 1'b0;
        end
    end

    // State, counters and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ld_cnt_q     <= 3'd0;
            mc_cnt_q     <= 8'd0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            mc_cnt_q     <= mc_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign McBusy    = (state_q == S_MC_BUSY) & ~reset;
    assign McTimeout = mc_timeout_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Testbench for hazard_unit_mc: table vectors, hand sequences and a randomized
// run against a cycle-counting reference model.
module tb_hazard_unit_mc;

    localparam int AW  = 5;
    localparam int LSC = 3;
    localparam int MCT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE, McDoneE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McTimeout;
    logic [5:0]    ctl;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_unit_mc #(.REG_AW(AW), .LOAD_STALL_CYC(LSC), .MC_TIMEOUT(MCT)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McBusy(McBusy), .McTimeout(McTimeout)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LD   = 6'b110010;
    localparam logic [5:0] C_MC   = 6'b111001;
    localparam logic [5:0] C_BR   = 6'b000110;

    typedef struct {
        logic [AW-1:0] rs1e, rs2e, rdm, rdw;
        logic          rwm, rww;
        logic [AW-1:0] rs1d, rs2d, rde;
        logic          rwe, ld, pcsrc;
        logic [1:0]    expa, expb;
        logic [5:0]    ectl;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_in();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE, McDoneE} = '0;
    endtask

    task automatic set_ld_haz();
        ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    endtask

    task automatic chk_st(input string nm, input logic [5:0] ec, input logic eb, input logic et);
        #1;
        chk({nm, ".ctl"}, {2'b0, ctl}, {2'b0, ec});
        chk({nm, ".busy"}, {7'b0, McBusy}, {7'b0, eb});
        chk({nm, ".tmo"}, {7'b0, McTimeout}, {7'b0, et});
    endtask

    // ---------------- reference model ----------------
    int ld_left, busy_n;
    bit in_busy, tmo;

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
        if (rs != 0 && rs == RdM && RegWriteM) return 2'b10;
        if (rs != 0 && rs == RdW && RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    // Compare this cycle's outputs against the model, then advance the model.
    task automatic model_step();
        logic [5:0] ec;
        logic [1:0] ea, eb;
        logic       eby, haz;
        ec  = C_NONE;
        ea  = reset ? 2'b00 : fwd_ref(Rs1E);
        eb  = reset ? 2'b00 : fwd_ref(Rs2E);
        eby = in_busy && !reset;
        haz = ResultSrcE0 && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        chk("rnd.tmo", {7'b0, McTimeout}, {7'b0, tmo});
        if (reset) begin
            ld_left = 0; in_busy = 0; tmo = 0;
        end else if (in_busy) begin
            if (McDoneE) in_busy = 0;
            else begin
                ec = C_MC;
                busy_n++;
                if (busy_n == MCT) begin tmo = 1; in_busy = 0; end
            end
        end else if (ld_left > 0) begin
            ec = C_LD;
            ld_left--;
        end else if (PCSrcE) begin
            ec = C_BR;
        end else if (McStartE) begin
            ec = C_MC; in_busy = 1; busy_n = 0;
        end else if (haz) begin
            ec = C_LD; ld_left = LSC - 1;
        end
        chk("rnd.fwdA", {6'b0, ForwardAE}, {6'b0, ea});
        chk("rnd.fwdB", {6'b0, ForwardBE}, {6'b0, eb});
        chk("rnd.ctl", {2'b0, ctl}, {2'b0, ec});
        chk("rnd.busy", {7'b0, McBusy}, {7'b0, eby});
    endtask

    initial begin
        vecs[0] = '{5, 3, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, C_NONE};
        vecs[1] = '{5, 3, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, C_NONE};
        vecs[2] = '{0, 3, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, C_NONE};
        vecs[3] = '{4, 9, 9, 4, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, C_NONE};
        vecs[4] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, C_NONE};
        vecs[5] = '{5, 9, 9, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, C_NONE};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 2, 7, 7, 1, 1, 1, 2'b00, 2'b00, C_BR};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, C_NONE};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 7, 3, 7, 0, 1, 0, 2'b00, 2'b00, C_NONE};

        // Reset with forwarding-inducing inputs: everything must be quiet.
        clr_in();
        reset = 1'b1;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; PCSrcE = 1'b1;
        #1;
        chk("rst.fwdA", {6'b0, ForwardAE}, 8'h00);
        chk("rst.ctl", {2'b0, ctl}, 8'h00);
        chk("rst.busy", {7'b0, McBusy}, 8'h00);
        tick();
        chk_st("rst2", C_NONE, 1'b0, 1'b0);
        reset = 1'b0;
        clr_in();
        tick();

        // Table-driven vectors, all in IDLE.
        foreach (vecs[i]) begin
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; RdE = vecs[i].rde;
            RegWriteE = vecs[i].rwe; ResultSrcE0 = vecs[i].ld; PCSrcE = vecs[i].pcsrc;
            McStartE = 1'b0; McDoneE = 1'b0;
            #1;
            chk($sformatf("vec%0d.fwdA", i), {6'b0, ForwardAE}, {6'b0, vecs[i].expa});
            chk($sformatf("vec%0d.fwdB", i), {6'b0, ForwardBE}, {6'b0, vecs[i].expb});
            chk($sformatf("vec%0d.ctl", i), {2'b0, ctl}, {2'b0, vecs[i].ectl});
            tick();
        end
        clr_in();
        tick();

        // Load-use: exactly LSC cycles; branch/mc-start ignored mid-stall.
        set_ld_haz();
        chk_st("ld.c0", C_LD, 1'b0, 1'b0); tick();
        PCSrcE = 1'b1; McStartE = 1'b1;
        chk_st("ld.c1", C_LD, 1'b0, 1'b0); tick();
        PCSrcE = 1'b0; McStartE = 1'b0;
        chk_st("ld.c2", C_LD, 1'b0, 1'b0); tick();
        clr_in();
        chk_st("ld.c3", C_NONE, 1'b0, 1'b0); tick();

        // Multi-cycle op: start in cycle 0 (done ignored there), done in cycle 4.
        McStartE = 1'b1; McDoneE = 1'b1; set_ld_haz();
        chk_st("mc.c0", C_MC, 1'b0, 1'b0); tick();
        McDoneE = 1'b0; PCSrcE = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            chk_st($sformatf("mc.c%0d", c), C_MC, 1'b1, 1'b0); tick();
        end
        McDoneE = 1'b1;
        chk_st("mc.c4", C_NONE, 1'b1, 1'b0); tick();
        clr_in();
        chk_st("mc.c5", C_NONE, 1'b0, 1'b0); tick();

        // Watchdog: no done; MCT cycles in MC_BUSY, then release with sticky flag.
        McStartE = 1'b1;
        chk_st("wd.c0", C_MC, 1'b0, 1'b0); tick();
        McStartE = 1'b0;
        for (int c = 1; c <= MCT; c++) begin
            chk_st($sformatf("wd.c%0d", c), C_MC, 1'b1, 1'b0); tick();
        end
        chk_st("wd.rel", C_NONE, 1'b0, 1'b1); tick();
        McStartE = 1'b1;
        chk_st("wd.s0", C_MC, 1'b0, 1'b1); tick();
        McStartE = 1'b0; McDoneE = 1'b1;
        chk_st("wd.s1", C_NONE, 1'b1, 1'b1); tick();
        clr_in();
        chk_st("wd.hold", C_NONE, 1'b0, 1'b1); tick();

        // Reset in mid-MC_BUSY aborts the stall and clears the sticky flag.
        McStartE = 1'b1;
        chk_st("rb.c0", C_MC, 1'b0, 1'b1); tick();
        McStartE = 1'b0;
        chk_st("rb.c1", C_MC, 1'b1, 1'b1); tick();
        reset = 1'b1;
        chk_st("rb.c2", C_NONE, 1'b0, 1'b1); tick();
        reset = 1'b0;
        chk_st("rb.c3", C_NONE, 1'b0, 1'b0); tick();

        // Randomized run against the reference model, starting from reset.
        ld_left = 0; busy_n = 0; in_busy = 0; tmo = 0;
        for (int n = 0; n < 3000; n++) begin
            reset       = (n == 0) || ($urandom_range(0, 199) == 0);
            Rs1D        = AW'($urandom_range(0, 3));
            Rs2D        = AW'($urandom_range(0, 3));
            Rs1E        = AW'($urandom_range(0, 3));
            Rs2E        = AW'($urandom_range(0, 3));
            RdE         = AW'($urandom_range(0, 3));
            RdM         = AW'($urandom_range(0, 3));
            RdW         = AW'($urandom_range(0, 3));
            RegWriteE   = 1'($urandom_range(0, 1));
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            ResultSrcE0 = ($urandom_range(0, 2) == 0);
            PCSrcE      = ($urandom_range(0, 7) == 0);
            McStartE    = ($urandom_range(0, 7) == 0);
            McDoneE     = ($urandom_range(0, 5) == 0);
            #1;
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
